// File: rtl/reg_file.sv
// Two-read / one-write register file with hard-wired zero register, write-through
// bypass on both read ports, and a separately enabled carry flag.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              carry_we,
    input  logic              carry_d,
    output logic              carry_q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic              carry_reg;
    logic              wr_live;

    // A write is only real outside reset and away from the zero register.
    assign wr_live = rst_n && wr_en && (wr_addr != '0);

    // Register array needs an asynchronous clear, so it is built from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_live) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
        end else if (carry_we) begin
            carry_reg <= carry_d;
        end
    end

    assign carry_q = carry_reg;

    // Identical read-port logic; port 0 is A, port 1 is B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;

            assign addr = (gi == 0) ? rd_addr_a : rd_addr_b;

            always_comb begin
                data = '0;
                if (!rst_n) begin
                    data = '0;
                end else if (wr_live && (wr_addr == addr)) begin
                    data = wr_data;
                end else if (addr != '0) begin
                    data = regs_reg[addr];
                end
            end
        end
    endgenerate

    assign rd_data_a = g_rd[0].data;
    assign rd_data_b = g_rd[1].data;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read, zero register,
// bypass, carry flag and mid-operation reset.
module tb_reg_file;

    logic        clk = 1'b1;
    logic        rst_n;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        wr_en, carry_we, carry_d, carry_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .carry_we  (carry_we),
        .carry_d   (carry_d),
        .carry_q   (carry_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // One register write spanning a single rising edge; returns at the next falling edge.
    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_pair(input logic [2:0] a, input logic [2:0] b);
        rd_addr_a = a; rd_addr_b = b;
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        carry_we = 1'b0; carry_d = 1'b0;

        // Asynchronous reset at t=5, a falling edge between rising edges.
        #5 rst_n = 1'b0;
        rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h0000_0055;
        #1;
        chk("rst_async_a", rd_data_a, 32'h0);
        chk("rst_async_b", rd_data_b, 32'h0);
        chk("rst_async_carry", {31'b0, carry_q}, 32'h0);
        @(posedge clk); #1;
        chk("rst_write_ignored", rd_data_a, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            read_pair(3'(i), 3'(i));
            chk($sformatf("rst_clear_r%0d", i), rd_data_a, 32'h0);
        end

        // Basic write then read on both ports.
        @(negedge clk);
        write_reg(3'd1, 32'h0000_000D);
        write_reg(3'd2, 32'h0000_0009);
        read_pair(3'd1, 3'd2);
        chk("wr_rd_a_r1", rd_data_a, 32'h0000_000D);
        chk("wr_rd_b_r2", rd_data_b, 32'h0000_0009);

        // Zero register ignores writes, before and after the edge.
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFFF;
        rd_addr_a = 3'd0;
        #1 chk("r0_pre_edge", rd_data_a, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1 chk("r0_post_edge", rd_data_a, 32'h0);

        // Bypass: both ports on the register being written.
        write_reg(3'd3, 32'h0000_000B);
        read_pair(3'd3, 3'd3);
        chk("r3_stored", rd_data_a, 32'h0000_000B);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h0000_000E;
        #1;
        chk("byp_pre_a", rd_data_a, 32'h0000_000E);
        chk("byp_pre_b", rd_data_b, 32'h0000_000E);
        rd_addr_b = 3'd1;
        #1 chk("byp_other_port_b", rd_data_b, 32'h0000_000D);
        rd_addr_b = 3'd3;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("byp_post_a", rd_data_a, 32'h0000_000E);
        chk("byp_post_b", rd_data_b, 32'h0000_000E);

        // Back-to-back writes to one address keep the last value.
        write_reg(3'd5, 32'h0000_0001);
        write_reg(3'd5, 32'h0000_0002);
        read_pair(3'd5, 3'd2);
        chk("b2b_r5", rd_data_a, 32'h0000_0002);
        chk("b2b_r2_untouched", rd_data_b, 32'h0000_0009);

        // Carry flag: one-cycle latency, hold when disabled.
        carry_we = 1'b1; carry_d = 1'b1;
        #1 chk("carry_no_bypass", {31'b0, carry_q}, 32'h0);
        @(posedge clk); #1;
        chk("carry_set", {31'b0, carry_q}, 32'h1);
        @(negedge clk);
        carry_we = 1'b0; carry_d = 1'b0;
        @(posedge clk); #1;
        chk("carry_hold", {31'b0, carry_q}, 32'h1);

        // Register and carry writes in the same cycle.
        @(negedge clk);
        carry_we = 1'b1; carry_d = 1'b0;
        write_reg(3'd4, 32'h0000_0044);
        carry_we = 1'b0;
        read_pair(3'd4, 3'd4);
        chk("dual_wr_r4", rd_data_a, 32'h0000_0044);
        chk("dual_wr_carry", {31'b0, carry_q}, 32'h0);

        // Set carry again, then reset clears it.
        carry_we = 1'b1; carry_d = 1'b1;
        @(negedge clk);
        carry_we = 1'b0;
        #1 chk("carry_reset_pre", {31'b0, carry_q}, 32'h1);

        // Mid-operation reset concurrent with a write to r7.
        write_reg(3'd7, 32'h0000_0004);
        read_pair(3'd7, 3'd1);
        chk("r7_stored", rd_data_a, 32'h0000_0004);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'h0000_0099;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_r7_during", rd_data_a, 32'h0);
        chk("mid_rst_carry", {31'b0, carry_q}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_r7_after", rd_data_a, 32'h0);
        chk("mid_rst_r1_after", rd_data_b, 32'h0);
        read_pair(3'd3, 3'd4);
        chk("mid_rst_r3_after", rd_data_a, 32'h0);
        chk("mid_rst_r4_after", rd_data_b, 32'h0);

        // First write after release lands normally.
        @(negedge clk);
        write_reg(3'd6, 32'hCAFE_0006);
        read_pair(3'd6, 3'd6);
        chk("post_rst_write_r6", rd_data_b, 32'hCAFE_0006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, register and ALU operand width.
REQ-002 The block SHALL provide parameter ADDR_W, default 3, register address width; depth = 2**ADDR_W (8 registers at default).
REQ-003 The block SHALL provide port clk, input, 1, single clock, all state updates on rising edge.
REQ-004 The block SHALL provide port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL provide port rd_addr_a, input, ADDR_W, read port A address (drives ALU operand A).
REQ-006 The block SHALL provide port rd_addr_b, input, ADDR_W, read port B address (drives ALU operand B).
REQ-007 The block SHALL provide port rd_data_a, output, DATA_W, read port A data.
REQ-008 The block SHALL provide port rd_data_b, output, DATA_W, read port B data.
REQ-009 The block SHALL provide port wr_en, input, 1, write enable for the write port.
REQ-010 The block SHALL provide port wr_addr, input, ADDR_W, write address.
REQ-011 The block SHALL provide port wr_data, input, DATA_W, write data (ALU result write-back).
REQ-012 The block SHALL provide port carry_we, input, 1, carry flag write enable.
REQ-013 The block SHALL provide port carry_d, input, 1, carry flag next value (ALU carry-out).
REQ-014 The block SHALL provide port carry_q, output, 1, registered carry flag (drives ALU carry_in).

Function
REQ-015 The block SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-016 Register 0 SHALL always read as zero; writes to address 0 SHALL be ignored.
REQ-017 A write SHALL occur on the rising clk edge when wr_en=1 and wr_addr!=0; with wr_en=0, no register changes.
REQ-018 Reads SHALL be combinational: rd_data_x reflects the addressed register with zero-cycle latency.
REQ-019 Bypass: when wr_en=1, wr_addr!=0 and wr_addr==rd_addr_x in the same cycle, rd_data_x SHALL equal wr_data (write-through) before the edge.
REQ-020 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data, including under bypass.
REQ-021 Back-to-back writes to the same address SHALL leave the last-written value; one write per cycle maximum.
REQ-022 carry_q SHALL load carry_d on the rising edge when carry_we=1 and hold otherwise; no bypass on carry_q (one-cycle latency).
REQ-023 A register write and a carry write in the same cycle SHALL both take effect independently.
REQ-024 Address values SHALL be used unmodified; all 2**ADDR_W addresses valid, no wrap or out-of-range handling required.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all registers and carry_q to 0, without waiting for clk.
REQ-026 While rst_n=0, writes SHALL be ignored and rd_data_a, rd_data_b, carry_q SHALL read 0.
REQ-027 A write pending at the edge where rst_n deasserts SHALL NOT take effect if rst_n was low at that edge; first write lands on the first rising edge with rst_n=1.
REQ-028 Reset asserted mid-operation SHALL discard all stored values; no state survives reset.

Verification
REQ-029 Reset: rst_n=0 at t=5 between clk edges -> all reads and carry_q = 0 immediately; after release, all 8 addresses read 0.
REQ-030 Write/read: write 32'h0000000D to r1, 32'h00000009 to r2; set rd_addr_a=1, rd_addr_b=2 -> rd_data_a=0x0000000D, rd_data_b=0x00000009.
REQ-031 Register 0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data_a at address 0 remains 0x00000000.
REQ-032 Bypass: r3=0x0000000B stored; same cycle wr_en=1, wr_addr=3, wr_data=0x0000000E, rd_addr_a=rd_addr_b=3 -> both reads 0x0000000E before the edge and after it.
REQ-033 Carry: carry_we=1, carry_d=1 at edge N -> carry_q=1 from edge N; carry_we=0, carry_d=0 at edge N+1 -> carry_q stays 1; rst_n=0 -> carry_q=0.
REQ-034 Mid-operation reset: write 0x00000004 to r7, assert rst_n=0 concurrent with wr_en=1 to r7 -> r7 reads 0 after release.
